decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
// - RV32I decode stage directly upstream of the ALU: accepts a fetched instruction + PC, reads operands
//   from the register file, and presents fn/funct7/a/b to the execute stage in ALU-ready form.
// - Registered output (1-cycle latency), valid/ready handshake on both sides, flush from branch resolution.
// PARAMETERS
// - WIDTH   32   datapath width (a, b, pc, rs*_data); instruction word is always 32 bits
// PORTS
// - clk            in   1      clock, all state on rising edge
// - rst            in   1      asynchronous reset, active-high
// - in_valid       in   1      fetch presents instr/pc
// - in_ready       out  1      decode can accept this cycle
// - instr          in   32     instruction word
// - pc             in   WIDTH  address of instr
// - rs1_addr       out  5      = instr[19:15], combinational, to register file
// - rs2_addr       out  5      = instr[24:20], combinational, to register file
// - rs1_data       in   WIDTH  register file read data (combinational read, same cycle)
// - rs2_data       in   WIDTH  register file read data
// - flush          in   1      execute took a branch; discard held/in-flight decode
// - out_valid      out  1      decoded bundle valid
// - out_ready      in   1      execute consumes bundle
// - fn             out  3      alu_fn_t (funct3 encoding; branches reuse it as alu_branches_funct3_t)
// - funct7         out  7      funct7_t for ADD_SUB / SRL_SRA select
// - a, b           out  WIDTH  ALU operands
// - rd             out  5      destination register (0 for branches)
// - is_branch      out  1      instruction is BRANCH; execute uses take_branch
// - branch_target  out  WIDTH  pc + B-immediate
// - illegal        out  1      unsupported opcode
// BEHAVIOUR
// - Reset: out_valid=0, fn/funct7/a/b/rd/branch_target=0, is_branch=0, illegal=0, in_ready=1.
// - Accept = in_valid && in_ready; bundle appears on outputs the next cycle with out_valid=1.
// - Output holds stable while out_valid && !out_ready; in_ready = !out_valid || out_ready (no macro).
// - flush: next cycle out_valid=0 (and skid empty); flush beats a simultaneous accept (accepted instr dropped).
// - Decode (opcode = instr[6:0]); rs data from x0 forced to 0 regardless of rs*_data:
//   - OP 0110011:     fn=funct3, funct7=instr[31:25], a=rs1, b=rs2, rd=instr[11:7]
//   - OP-IMM 0010011: fn=funct3, a=rs1, b=sext(instr[31:20]); funct7=instr[31:25] only if funct3==101,
//                     else 0 (ADDI never becomes SUB); for funct3 001/101 b=zext(instr[24:20])
//   - BRANCH 1100011: fn=funct3, a=rs1, b=rs2, is_branch=1, rd=0,
//                     branch_target=pc+sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}), mod 2^WIDTH
//   - LUI 0110111:    fn=000, funct7=0, a=0,  b={instr[31:12],12'b0}
//   - AUIPC 0010111:  fn=000, funct7=0, a=pc, b={instr[31:12],12'b0}
//   - other:          illegal=1, fn/funct7/a/b/rd=0, is_branch=0; still emitted with out_valid=1
// - branch_target=0 for non-branch. Immediates sign-extended to WIDTH.
// - Reset mid-operation: everything returns to reset values immediately (async), held bundle lost.
// CONFIGURATION
// - DECODE_SKID_EN defined: 2-entry skid buffer; in_ready is a register (= skid not full), no
//   combinational out_ready->in_ready path; states EMPTY(0 held) -> BUSY(1) -> FULL(2); FULL drains
//   to BUSY on out_ready; full throughput sustained with out_ready=1. Flush empties both entries.
// - Undefined: single output register, in_ready = !out_valid || out_ready (combinational).
// TESTING
// - instr=0x40208033 (sub x0? use rd=1: 0x402080B3), x1=7,x2=3 -> fn=000, funct7=0100000, a=7, b=3, rd=1.
// - addi x5,x0,-1 (0xFFF00293) -> a=0, b=0xFFFFFFFF, funct7=0; srai x5,x5,4 (0x4042D293) -> funct7=0100000, b=4.
// - beq at pc=0x100, imm=-8 (0xFE000CE3) -> is_branch=1, rd=0, branch_target=0xF8.
// - out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, no instr lost/duplicated; both macro settings.
// - flush asserted same cycle as accept -> next cycle out_valid=0; following instr decoded normally.
// - instr=0x0000000F (FENCE) -> illegal=1, out_valid=1; async rst mid-stall -> out_valid=0 same cycle.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage feeding the ALU.
// Reads operands from the register file, forms ALU-ready fn/funct7/a/b and
// registers the decoded bundle behind a valid/ready handshake (1-cycle latency).
// Optional feature: define DECODE_SKID_EN to use a 2-entry skid buffer with a
// registered in_ready instead of the single output register.
module decode_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] pc,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       fn,
    output logic [6:0]       funct7,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [4:0]       rd,
    output logic             is_branch,
    output logic [WIDTH-1:0] branch_target,
    output logic             illegal
);

    typedef struct packed {
        logic [2:0]       fn;
        logic [6:0]       funct7;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [4:0]       rd;
        logic             isBranch;
        logic [WIDTH-1:0] target;
        logic             illegal;
    } bundle_t;

    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] rs1Val;
    logic [WIDTH-1:0] rs2Val;
    logic [WIDTH-1:0] uImm;
    bundle_t          decoded;
    bundle_t          outBundle;
    logic             accept;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    // x0 always reads as zero, whatever the register file returns
    assign rs1Val = (rs1_addr == 5'd0) ? '0 : rs1_data;
    assign rs2Val = (rs2_addr == 5'd0) ? '0 : rs2_data;
    assign uImm   = WIDTH'(signed'({instr[31:12], 12'b0}));

    // Combinational decode of the incoming instruction into ALU-ready form
    always_comb begin
        decoded = '0;
        unique case (opcode)
            OpReg: begin
                decoded.fn     = funct3;
                decoded.funct7 = instr[31:25];
                decoded.a      = rs1Val;
                decoded.b      = rs2Val;
                decoded.rd     = instr[11:7];
            end
            OpImm: begin
                decoded.fn = funct3;
                decoded.a  = rs1Val;
                decoded.rd = instr[11:7];
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    decoded.b = WIDTH'(instr[24:20]);
                end else begin
                    decoded.b = WIDTH'(signed'(instr[31:20]));
                end
                if (funct3 == 3'b101) begin
                    decoded.funct7 = instr[31:25];
                end
            end
            OpBr: begin
                decoded.fn       = funct3;
                decoded.a        = rs1Val;
                decoded.b        = rs2Val;
                decoded.isBranch = 1'b1;
                decoded.target   = pc + WIDTH'(signed'({instr[31], instr[7],
                                        instr[30:25], instr[11:8], 1'b0}));
            end
            OpLui: begin
                decoded.b  = uImm;
                decoded.rd = instr[11:7];
            end
            OpAuipc: begin
                decoded.a  = pc;
                decoded.b  = uImm;
                decoded.rd = instr[11:7];
            end
            default: begin
                decoded.illegal = 1'b1;
            end
        endcase
    end

`ifdef DECODE_SKID_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    skid_state_t state_q;
    bundle_t     head_q;
    bundle_t     skid_q;
    logic        inReady_q;
    logic        outValid_q;

    assign in_ready  = inReady_q;
    assign accept    = in_valid && inReady_q;
    assign out_valid = outValid_q;
    assign outBundle = head_q;

    // Skid FSM: head register drives the outputs, skid catches one extra bundle while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
        end else if (flush) begin
            state_q    <= EMPTY;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_q     <= decoded;
                        state_q    <= BUSY;
                        outValid_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && !out_ready) begin
                        skid_q    <= decoded;
                        state_q   <= FULL;
                        inReady_q <= 1'b0;
                    end else if (accept) begin
                        head_q <= decoded;
                    end else if (out_ready) begin
                        state_q    <= EMPTY;
                        outValid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        head_q    <= skid_q;
                        state_q   <= BUSY;
                        inReady_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    inReady_q  <= 1'b1;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end
`else
    logic    outValid_q;
    bundle_t bundle_q;

    assign in_ready  = !outValid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = outValid_q;
    assign outBundle = bundle_q;

    // Single output register: load on accept, hold while stalled, flush wins over accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            bundle_q   <= '0;
        end else if (flush) begin
            outValid_q <= 1'b0;
        end else if (accept) begin
            outValid_q <= 1'b1;
            bundle_q   <= decoded;
        end else if (out_ready) begin
            outValid_q <= 1'b0;
        end
    end
`endif

    assign fn            = outBundle.fn;
    assign funct7        = outBundle.funct7;
    assign a             = outBundle.a;
    assign b             = outBundle.b;
    assign rd            = outBundle.rd;
    assign is_branch     = outBundle.isBranch;
    assign branch_target = outBundle.target;
    assign illegal       = outBundle.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
// Works with or without DECODE_SKID_EN; stall checks only rely on ordering.
module tb_decode_stage;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [WIDTH-1:0] pc;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       fn;
    logic [6:0]       funct7;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       rd;
    logic             is_branch;
    logic [WIDTH-1:0] branch_target;
    logic             illegal;

    logic [WIDTH-1:0] regFile [32];
    int               vectors;
    int               miscompares;
    int               acceptCount;
    logic             lastAccepted;

    decode_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .fn(fn), .funct7(funct7),
        .a(a), .b(b), .rd(rd), .is_branch(is_branch),
        .branch_target(branch_target), .illegal(illegal)
    );

    // Register file model with combinational read; x0 holds garbage on purpose
    assign rs1_data = regFile[rs1_addr];
    assign rs2_data = regFile[rs2_addr];

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic v, input logic [31:0] ins,
                                 input logic [31:0] pcIn, input logic oRdy,
                                 input logic fl);
        in_valid  = v;
        instr     = ins;
        pc        = pcIn;
        out_ready = oRdy;
        flush     = fl;
    endtask

    // Advance one clock; records whether the handshake fired on that edge
    task automatic tick();
        #1;
        lastAccepted = in_valid && in_ready && !flush;
        @(posedge clk);
        #1;
        if (lastAccepted) acceptCount++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBundle(input string tag, input logic v, input logic [2:0] fnE,
                               input logic [6:0] f7E, input logic [31:0] aE,
                               input logic [31:0] bE, input logic [4:0] rdE,
                               input logic brE, input logic [31:0] tgtE,
                               input logic illE);
        checkOutput($sformatf("%s.out_valid", tag), 32'(out_valid), 32'(v));
        checkOutput($sformatf("%s.fn", tag), 32'(fn), 32'(fnE));
        checkOutput($sformatf("%s.funct7", tag), 32'(funct7), 32'(f7E));
        checkOutput($sformatf("%s.a", tag), a, aE);
        checkOutput($sformatf("%s.b", tag), b, bE);
        checkOutput($sformatf("%s.rd", tag), 32'(rd), 32'(rdE));
        checkOutput($sformatf("%s.is_branch", tag), 32'(is_branch), 32'(brE));
        checkOutput($sformatf("%s.branch_target", tag), branch_target, tgtE);
        checkOutput($sformatf("%s.illegal", tag), 32'(illegal), 32'(illE));
    endtask

    // Directed sequence: reset, decode vectors, stall, flush, async reset
    initial begin
        vectors      = 0;
        miscompares  = 0;
        acceptCount  = 0;
        lastAccepted = 1'b0;
        for (int i = 0; i < 32; i++) regFile[i] = 32'h0;
        regFile[0] = 32'hDEADBEEF;
        regFile[1] = 32'd7;
        regFile[2] = 32'd3;
        regFile[5] = 32'h80000000;

        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkBundle("reset", 1'b0, 3'd0, 7'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
        checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // sub x1, x1, x2
        applyStimulus(1'b1, 32'h402080B3, 32'h0, 1'b1, 1'b0);
        #1;
        checkOutput("sub.rs1_addr", 32'(rs1_addr), 32'd1);
        checkOutput("sub.rs2_addr", 32'(rs2_addr), 32'd2);
        tick();
        checkBundle("sub", 1'b1, 3'd0, 7'h20, 32'd7, 32'd3, 5'd1, 1'b0, 32'h0, 1'b0);

        // addi x5, x0, -1 : x0 forced to zero, ADDI never gets funct7
        applyStimulus(1'b1, 32'hFFF00293, 32'h4, 1'b1, 1'b0);
        tick();
        checkBundle("addi", 1'b1, 3'd0, 7'h00, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b0, 32'h0, 1'b0);

        // srai x5, x5, 4
        applyStimulus(1'b1, 32'h4042D293, 32'h8, 1'b1, 1'b0);
        tick();
        checkBundle("srai", 1'b1, 3'd5, 7'h20, 32'h80000000, 32'd4, 5'd5, 1'b0, 32'h0, 1'b0);

        // beq x0, x0, -8 at pc 0x100
        applyStimulus(1'b1, 32'hFE000CE3, 32'h100, 1'b1, 1'b0);
        tick();
        checkBundle("beq", 1'b1, 3'd0, 7'h00, 32'h0, 32'h0, 5'd0, 1'b1, 32'hF8, 1'b0);

        // lui x3, 0x12345
        applyStimulus(1'b1, 32'h123451B7, 32'h10, 1'b1, 1'b0);
        tick();
        checkBundle("lui", 1'b1, 3'd0, 7'h00, 32'h0, 32'h12345000, 5'd3, 1'b0, 32'h0, 1'b0);

        // auipc x4, 0xFFFFF at pc 0x200
        applyStimulus(1'b1, 32'hFFFFF217, 32'h200, 1'b1, 1'b0);
        tick();
        checkBundle("auipc", 1'b1, 3'd0, 7'h00, 32'h200, 32'hFFFFF000, 5'd4, 1'b0, 32'h0, 1'b0);

        // addi x6, x1, 1024 : imm bit 10 must not leak into funct7
        applyStimulus(1'b1, 32'h40008313, 32'h14, 1'b1, 1'b0);
        tick();
        checkBundle("addi1024", 1'b1, 3'd0, 7'h00, 32'd7, 32'h400, 5'd6, 1'b0, 32'h0, 1'b0);

        // slli x7, x1, 3
        applyStimulus(1'b1, 32'h00309393, 32'h18, 1'b1, 1'b0);
        tick();
        checkBundle("slli", 1'b1, 3'd1, 7'h00, 32'd7, 32'd3, 5'd7, 1'b0, 32'h0, 1'b0);

        // fence is not supported: emitted as illegal
        applyStimulus(1'b1, 32'h0000000F, 32'h1C, 1'b1, 1'b0);
        tick();
        checkBundle("fence", 1'b1, 3'd0, 7'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1);

        // drain
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("drain.out_valid", 32'(out_valid), 32'd0);

        // Stall: X accepted with out_ready low, then Y offered for 3 stalled cycles
        applyStimulus(1'b1, 32'h402080B3, 32'h20, 1'b0, 1'b0);
        acceptCount = 0;
        tick();
        checkBundle("stallX", 1'b1, 3'd0, 7'h20, 32'd7, 32'd3, 5'd1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h123451B7, 32'h24, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (lastAccepted) in_valid = 1'b0;
            checkOutput($sformatf("stall%0d.out_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("stall%0d.a", i), a, 32'd7);
            checkOutput($sformatf("stall%0d.rd", i), 32'(rd), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        if (lastAccepted) in_valid = 1'b0;
        checkBundle("stallY", 1'b1, 3'd0, 7'h00, 32'h0, 32'h12345000, 5'd3, 1'b0, 32'h0, 1'b0);
        checkOutput("stall.accepts", 32'(acceptCount), 32'd2);
        in_valid = 1'b0;
        tick();
        checkOutput("stall.nodup", 32'(out_valid), 32'd0);

        // Flush coincident with an accept drops the instruction
        applyStimulus(1'b1, 32'h00309393, 32'h30, 1'b1, 1'b1);
        tick();
        checkOutput("flush.out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush.in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 32'hFFF00293, 32'h34, 1'b1, 1'b0);
        tick();
        checkBundle("postflush", 1'b1, 3'd0, 7'h00, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b0, 32'h0, 1'b0);

        // Async reset in the middle of a stall
        applyStimulus(1'b1, 32'h402080B3, 32'h40, 1'b0, 1'b0);
        tick();
        checkOutput("prerst.out_valid", 32'(out_valid), 32'd1);
        applyStimulus(1'b1, 32'h123451B7, 32'h44, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncrst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("asyncrst.a", a, 32'h0);
        checkOutput("asyncrst.rd", 32'(rd), 32'd0);
        checkOutput("asyncrst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
